seq_divider: RTL and testbench

- Multicycle signed 32-bit integer divider; the responder side of the control unit's div start/stop handshake.
- Accepts a start pulse with operands taken from the A and B register outputs.
- Iterates one restoring-division step per clock, then returns quotient on lo and remainder on hi with a one-cycle done pulse.
- The control unit then steers hi/lo through the High/Low muxes into the High/Low registers.
- Divide-by-zero is flagged instead of computed.

---
 rtl/seq_divider_pkg.sv | 6 +
 rtl/seq_divider_if.sv | 13 +
 rtl/seq_divider_div_step.sv | 15 +
 rtl/seq_divider.sv | 66 ++++++
 tb/tb_seq_divider.sv | 118 +++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: state encoding and sizing shared by the signed sequential divider
package seq_divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, ZERO} state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: div start/stop handshake between the control unit and the divider
interface seq_divider_if import seq_divider_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic div_init;
  logic div_stop;
  logic div_zero;
  logic busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output a, b, div_init, input div_stop, div_zero, busy, hi, lo);
  modport slave (input a, b, div_init, output div_stop, div_zero, busy, hi, lo);
endinterface

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one restoring-division step on unsigned magnitudes
module seq_divider_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_bmag,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_sh;
  logic w_ge;
  assign w_sh = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  assign w_ge = w_sh >= {1'b0, i_bmag};
  assign o_rem = w_ge ? w_sh - {1'b0, i_bmag} : w_sh;
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed divider, quotient on lo and remainder on hi
module seq_divider import seq_divider_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic clk,
  input logic reset,
  seq_divider_if.slave bus
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0] r_rem, w_rem_n;
  logic [WIDTH-1:0] r_quo, w_quo_n, r_bmag, r_hi, r_lo, w_amag, w_bmag;
  logic r_sign_q, r_sign_r, w_start;
  assign w_amag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_bmag = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign w_start = r_state == IDLE && bus.div_init && bus.b != '0;
  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_rem), .i_quo(r_quo), .i_bmag(r_bmag), .o_rem(w_rem_n), .o_quo(w_quo_n)
  );
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = !bus.div_init ? IDLE : (bus.b == '0 ? ZERO : CALC);
      CALC: w_next = r_cnt == CNT_W'(WIDTH-1) ? FIX : CALC;
      FIX: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_bmag <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
        r_rem <= '0;
        r_quo <= w_amag;
        r_bmag <= w_bmag;
        r_sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        r_sign_r <= bus.a[WIDTH-1];
      end
      if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
      end
      // remainder magnitude is below |b|, so its low WIDTH bits are exact
      if (r_state == FIX) begin
        r_lo <= r_sign_q ? -r_quo : r_quo;
        r_hi <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
      end
    end
  end
  assign bus.div_stop = r_state == DONE || r_state == ZERO;
  assign bus.div_zero = r_state == ZERO;
  assign bus.busy = r_state != IDLE;
  assign bus.hi = r_hi;
  assign bus.lo = r_lo;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of latency, signed results, divide-by-zero, ignored starts and reset abort
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  int n;
  int stops;
  seq_divider_if #(.WIDTH(32)) dif();
  seq_divider dut (.clk(clk), .reset(reset), .bus(dif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [31:0] a, input logic [31:0] b, output int cyc);
    dif.a = a;
    dif.b = b;
    dif.div_init = 1'b1;
    @(negedge clk);
    dif.div_init = 1'b0;
    dif.a = $urandom;
    dif.b = $urandom;
    cyc = 1;
  endtask
  task automatic finish(input string tag, input int n0, input int lat, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic ez, input bit init_in_done);
    int c = n0;
    int nlow = 0;
    while (!dif.div_stop && c < 80) begin
      if (!dif.busy) nlow++;
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_busy_low"}, nlow, 0);
    chk({tag, "_busy_at_stop"}, dif.busy, 1);
    chk({tag, "_lo"}, dif.lo, elo);
    chk({tag, "_hi"}, dif.hi, ehi);
    chk({tag, "_zero"}, dif.div_zero, ez);
    if (init_in_done) begin
      dif.div_init = 1'b1;
      dif.a = 32'd1;
      dif.b = 32'd1;
    end
    @(negedge clk);
    dif.div_init = 1'b0;
    chk({tag, "_stop_drop"}, dif.div_stop, 0);
    chk({tag, "_idle"}, dif.busy, 0);
    chk({tag, "_lo_hold"}, dif.lo, elo);
  endtask
  initial begin
    reset = 1'b1;
    dif.a = '0;
    dif.b = '0;
    dif.div_init = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", dif.busy, 0);
    chk("rst_stop", dif.div_stop, 0);
    chk("rst_zero", dif.div_zero, 0);
    chk("rst_hi", dif.hi, 0);
    chk("rst_lo", dif.lo, 0);
    reset = 1'b0;
    @(negedge clk);
    go(32'd7, 32'd2, n);
    finish("p7_p2", n, 34, 32'd3, 32'd1, 1'b0, 1'b1);
    go(32'hFFFF_FFF9, 32'd2, n);
    finish("m7_p2", n, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    go(32'd7, 32'hFFFF_FFFE, n);
    finish("p7_m2", n, 34, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    go(32'hFFFF_FF9C, 32'hFFFF_FFF9, n);
    finish("m100_m7", n, 34, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
    go(32'h8000_0000, 32'hFFFF_FFFF, n);
    finish("ovf", n, 34, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    go(32'd100, 32'd7, n);
    finish("p100_p7", n, 34, 32'd14, 32'd2, 1'b0, 1'b0);
    go(32'd5, 32'd0, n);
    finish("divzero", n, 1, 32'd14, 32'd2, 1'b1, 1'b1);
    go(32'd1000, 32'd10, n);
    while (n < 4) begin
      @(negedge clk);
      n++;
    end
    dif.div_init = 1'b1;
    dif.a = 32'd1;
    dif.b = 32'd1;
    @(negedge clk);
    n++;
    dif.div_init = 1'b0;
    finish("ignored", n, 34, 32'd100, 32'd0, 1'b0, 1'b0);
    go(32'd1000, 32'd10, n);
    while (n < 9) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", dif.busy, 0);
    chk("abort_stop", dif.div_stop, 0);
    chk("abort_zero", dif.div_zero, 0);
    chk("abort_lo", dif.lo, 0);
    chk("abort_hi", dif.hi, 0);
    stops = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.div_stop || dif.busy) stops++;
    end
    chk("abort_no_stop", stops, 0);
    go(32'd9, 32'd3, n);
    finish("p9_p3", n, 34, 32'd3, 32'd0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
